// File: rtl/vram_arbiter.sv
// Screen RAM arbiter: video fetch (bitmap + attribute per cell) has priority over CPU
// accesses, which are stalled through cpu_wait until their single RAM slot completes.
module vram_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_pix_addr,
  input  logic [ADDR_W-1:0] vid_attr_addr,
  output logic [DATA_W-1:0] vid_pix,
  output logic [DATA_W-1:0] vid_attr,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_PIX, ST_ATTR} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_PIX, TAG_ATTR, TAG_CPU} tag_t;

  state_t              state_q, state_d;
  tag_t                tag_q, tag_d;
  tag_t                tag2_q, tag2_d;
  logic                we2_q, we2_d;
  logic [ADDR_W-1:0]   attr_addr_q, attr_addr_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                cpu_out_q, cpu_out_d;
  logic [DATA_W-1:0]   vid_pix_q, vid_pix_d;
  logic [DATA_W-1:0]   vid_attr_q, vid_attr_d;
  logic                vid_valid_q, vid_valid_d;
  logic                overrun_q, overrun_d;
  logic [DATA_W-1:0]   cpu_dout_q, cpu_dout_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                vid_accept;

  // Issue arbitration, fetch sequencing and return-data steering.
  always_comb begin
    state_d     = state_q;
    tag_d       = TAG_NONE;
    tag2_d      = tag_q;
    we2_d       = ram_we_q;
    attr_addr_d = attr_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din_q;
    cpu_out_d   = cpu_out_q;
    vid_pix_d   = vid_pix_q;
    vid_attr_d  = vid_attr_q;
    vid_valid_d = 1'b0;
    cpu_dout_d  = cpu_dout_q;
    cpu_ack_d   = 1'b0;
    // In ATTR the attribute slot has already been issued, so a new cell can start.
    vid_accept  = vid_req && (state_q != ST_PIX);
    overrun_d   = overrun_q || (vid_req && (state_q == ST_PIX));

    case (state_q)
      ST_IDLE: if (vid_req) state_d = ST_PIX;
      ST_PIX:  state_d = ST_ATTR;
      ST_ATTR: state_d = vid_req ? ST_PIX : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (vid_accept) begin
      tag_d       = TAG_PIX;
      ram_addr_d  = vid_pix_addr;
      attr_addr_d = vid_attr_addr;
    end else if (state_q == ST_PIX) begin
      tag_d      = TAG_ATTR;
      ram_addr_d = attr_addr_q;
    end else if (cpu_req && !cpu_out_q) begin
      tag_d      = TAG_CPU;
      ram_addr_d = cpu_addr;
      ram_we_d   = cpu_we;
      ram_din_d  = cpu_din;
      cpu_out_d  = 1'b1;
    end

    // ram_dout now belongs to the access tagged two edges ago.
    case (tag2_q)
      TAG_PIX:  vid_pix_d = ram_dout;
      TAG_ATTR: begin
        vid_attr_d  = ram_dout;
        vid_valid_d = 1'b1;
      end
      TAG_CPU: begin
        if (!we2_q) cpu_dout_d = ram_dout;
        cpu_ack_d = 1'b1;
        cpu_out_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tag_q       <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      we2_q       <= 1'b0;
      attr_addr_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      cpu_out_q   <= 1'b0;
      vid_pix_q   <= '0;
      vid_attr_q  <= '0;
      vid_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      cpu_dout_q  <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      tag2_q      <= tag2_d;
      we2_q       <= we2_d;
      attr_addr_q <= attr_addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      cpu_out_q   <= cpu_out_d;
      vid_pix_q   <= vid_pix_d;
      vid_attr_q  <= vid_attr_d;
      vid_valid_q <= vid_valid_d;
      overrun_q   <= overrun_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign vid_pix     = vid_pix_q;
  assign vid_attr    = vid_attr_q;
  assign vid_valid   = vid_valid_q;
  assign vid_overrun = overrun_q;
  assign cpu_dout    = cpu_dout_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_wait    = cpu_req & ~cpu_ack_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_din     = ram_din_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 8 KB synchronous-read screen RAM.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [12:0] vid_pix_addr, vid_attr_addr;
  logic [7:0]  vid_pix, vid_attr;
  logic        vid_valid, vid_overrun;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack, cpu_wait;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din, ram_dout;

  logic [7:0]  mem [0:8191];
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_pix_addr(vid_pix_addr), .vid_attr_addr(vid_attr_addr),
    .vid_pix(vid_pix), .vid_attr(vid_attr), .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port BRAM, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated CPU access from an idle arbiter; d is write data or expected read data.
  task automatic cpu_do(input logic we, input logic [12:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = we ? d : 8'h00;
    #1;
    chk("cpu_wait_req", 16'(cpu_wait), 16'h1);
    step();
    chk("cpu_issue_addr", 16'(ram_addr), 16'(a));
    chk("cpu_issue_we", 16'(ram_we), 16'(we));
    if (we) chk("cpu_issue_din", 16'(ram_din), 16'(d));
    step();
    chk("cpu_we_1cyc", 16'(ram_we), 16'h0);
    chk("cpu_ack_early", 16'(cpu_ack), 16'h0);
    chk("cpu_wait_mid", 16'(cpu_wait), 16'h1);
    step();
    chk("cpu_ack", 16'(cpu_ack), 16'h1);
    chk("cpu_wait_ack", 16'(cpu_wait), 16'h0);
    if (!we) chk("cpu_dout", 16'(cpu_dout), 16'(d));
    cpu_req = 1'b0;
    step();
    chk("cpu_ack_pulse", 16'(cpu_ack), 16'h0);
  endtask

  initial begin
    reset = 1'b1; vid_req = 1'b0; vid_pix_addr = '0; vid_attr_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    repeat (3) step();
    chk("rst_ram_we", 16'(ram_we), 16'h0);
    chk("rst_ram_addr", 16'(ram_addr), 16'h0);
    chk("rst_vid_valid", 16'(vid_valid), 16'h0);
    chk("rst_overrun", 16'(vid_overrun), 16'h0);
    chk("rst_cpu_ack", 16'(cpu_ack), 16'h0);
    chk("rst_cpu_dout", 16'(cpu_dout), 16'h0);
    reset = 1'b0;
    step();

    // CPU write then read-back, plus preload of screen bytes.
    cpu_do(1'b1, 13'h0800, 8'h5A);
    cpu_do(1'b0, 13'h0800, 8'h5A);
    cpu_do(1'b1, 13'h0123, 8'hA5);
    cpu_do(1'b1, 13'h1845, 8'h47);
    cpu_do(1'b1, 13'h1800, 8'h3C);

    // Video fetch alone; address changes after E0 must be ignored.
    vid_req = 1'b1; vid_pix_addr = 13'h0123; vid_attr_addr = 13'h1845;
    step();
    chk("vid_e0_addr", 16'(ram_addr), 16'h0123);
    chk("vid_e0_we", 16'(ram_we), 16'h0);
    vid_req = 1'b0; vid_pix_addr = 13'h1FFF; vid_attr_addr = 13'h1FFF;
    step();
    chk("vid_e1_addr", 16'(ram_addr), 16'h1845);
    chk("vid_e1_valid", 16'(vid_valid), 16'h0);
    step();
    chk("vid_e2_pix", 16'(vid_pix), 16'h00A5);
    chk("vid_e2_valid", 16'(vid_valid), 16'h0);
    step();
    chk("vid_e3_attr", 16'(vid_attr), 16'h0047);
    chk("vid_e3_valid", 16'(vid_valid), 16'h1);
    step();
    chk("vid_e4_valid", 16'(vid_valid), 16'h0);
    chk("vid_overrun0", 16'(vid_overrun), 16'h0);

    // Contention: CPU read 0x1800 and vid_req at the same edge.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1800;
    vid_req = 1'b1; vid_pix_addr = 13'h0123; vid_attr_addr = 13'h1845;
    #1;
    chk("con_wait_pre", 16'(cpu_wait), 16'h1);
    step();
    chk("con_e0_addr", 16'(ram_addr), 16'h0123);
    vid_req = 1'b0;
    step();
    chk("con_e1_addr", 16'(ram_addr), 16'h1845);
    chk("con_e1_wait", 16'(cpu_wait), 16'h1);
    step();
    chk("con_e2_addr", 16'(ram_addr), 16'h1800);
    chk("con_e2_we", 16'(ram_we), 16'h0);
    step();
    chk("con_e3_valid", 16'(vid_valid), 16'h1);
    chk("con_e3_ack", 16'(cpu_ack), 16'h0);
    chk("con_e3_wait", 16'(cpu_wait), 16'h1);
    step();
    chk("con_e4_ack", 16'(cpu_ack), 16'h1);
    chk("con_e4_dout", 16'(cpu_dout), 16'h003C);
    chk("con_e4_wait", 16'(cpu_wait), 16'h0);
    cpu_req = 1'b0;
    step();
    chk("con_e5_ack", 16'(cpu_ack), 16'h0);

    // Back-to-back video: E1 request dropped, E2 request accepted.
    vid_req = 1'b1; vid_pix_addr = 13'h0123; vid_attr_addr = 13'h1845;
    step();
    vid_pix_addr = 13'h1800; vid_attr_addr = 13'h0800;
    step();
    chk("b2b_e1_addr", 16'(ram_addr), 16'h1845);
    chk("b2b_e1_overrun", 16'(vid_overrun), 16'h1);
    vid_pix_addr = 13'h0800; vid_attr_addr = 13'h1800;
    step();
    chk("b2b_e2_addr", 16'(ram_addr), 16'h0800);
    vid_req = 1'b0;
    step();
    chk("b2b_e3_addr", 16'(ram_addr), 16'h1800);
    chk("b2b_e3_valid", 16'(vid_valid), 16'h1);
    chk("b2b_e3_pix", 16'(vid_pix), 16'h00A5);
    chk("b2b_e3_attr", 16'(vid_attr), 16'h0047);
    step();
    chk("b2b_e4_valid", 16'(vid_valid), 16'h0);
    chk("b2b_e4_pix", 16'(vid_pix), 16'h005A);
    step();
    chk("b2b_e5_valid", 16'(vid_valid), 16'h1);
    chk("b2b_e5_attr", 16'(vid_attr), 16'h003C);
    step();
    chk("b2b_e6_overrun", 16'(vid_overrun), 16'h1);

    // Held cpu_req: issues every third edge, one ack each.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("held_ack", 16'(cpu_ack), (k % 3 == 2) ? 16'h1 : 16'h0);
      if (k % 3 == 2) chk("held_dout", 16'(cpu_dout), 16'h00A5);
    end
    cpu_req = 1'b0;
    step();
    chk("held_drain0", 16'(cpu_ack), 16'h0);
    step();
    chk("held_drain1", 16'(cpu_ack), 16'h1);
    step();

    // Reset during a CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0400; cpu_din = 8'h99;
    step();
    chk("rmw_we", 16'(ram_we), 16'h1);
    reset = 1'b1;
    step();
    chk("rmw_we_off", 16'(ram_we), 16'h0);
    chk("rmw_addr", 16'(ram_addr), 16'h0);
    chk("rmw_din", 16'(ram_din), 16'h0);
    chk("rmw_ack", 16'(cpu_ack), 16'h0);
    cpu_req = 1'b0;
    step();
    chk("rmw_ack2", 16'(cpu_ack), 16'h0);
    chk("rmw_overrun", 16'(vid_overrun), 16'h0);
    chk("rmw_pix", 16'(vid_pix), 16'h0);
    chk("rmw_attr", 16'(vid_attr), 16'h0);
    chk("rmw_dout", 16'(cpu_dout), 16'h0);
    reset = 1'b0;
    step();

    // Normal fetch after reset.
    vid_req = 1'b1; vid_pix_addr = 13'h0123; vid_attr_addr = 13'h1845;
    step();
    vid_req = 1'b0;
    step();
    step();
    step();
    chk("post_valid", 16'(vid_valid), 16'h1);
    chk("post_pix", 16'(vid_pix), 16'h00A5);
    chk("post_attr", 16'(vid_attr), 16'h0047);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
